stash_sequencer: RTL and testbench

- Controller placed in front of the Stash sample buffer.
- It arbitrates between recording incoming samples and browsing the stored ones, either manually (button) or automatically (timed scroll).
- It turns debounced board buttons and a sample-valid stream into the single-cycle `sample_in_valid` / `next_sample` strobes that Stash expects.
- It also reports the current mode and fill level for display.

---
 rtl/stash_sequencer.sv | 119 +++++++++++
 tb/tb_stash_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stash_sequencer.sv
// stash_sequencer: mode controller in front of the Stash sample buffer (RECORD/BROWSE/AUTO).
// Define STASH_SEQ_DROP_CNT_EN to build the refused-sample counter; otherwise drop_cnt is tied to 0.
module stash_sequencer #(
  parameter int DEPTH       = 5,
  parameter int DATA_W      = 8,
  parameter int AUTO_PERIOD = 50000000,
  parameter int CNT_W       = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          src_data,
  input  logic                       src_valid,
  input  logic                       btn_mode,
  input  logic                       btn_next,
  output logic [DATA_W-1:0]          stash_sample_in,
  output logic                       stash_sample_in_valid,
  output logic                       stash_next_sample,
  output logic [1:0]                 mode,
  output logic [$clog2(DEPTH+1)-1:0] fill,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int FILL_W  = $clog2(DEPTH + 1);
  localparam int TIMER_W = $clog2(AUTO_PERIOD);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(AUTO_PERIOD - 1);
  localparam logic [FILL_W-1:0]  FILL_MAX  = FILL_W'(DEPTH);

  typedef enum logic [1:0] {
    RECORD = 2'b00,
    BROWSE = 2'b01,
    AUTO   = 2'b10
  } mode_e;

  mode_e               state, state_nx;
  logic                btn_mode_q, btn_next_q;
  logic                mode_edge, next_edge;
  logic [TIMER_W-1:0]  timer, timer_nx;
  logic                wr_nx, next_nx;
  logic [DATA_W-1:0]   data_nx;
  logic [FILL_W-1:0]   fill_nx;

  // Strobes have no ready: Stash must accept a sample_in_valid or next_sample pulse in the cycle it is high.
  assign mode_edge = btn_mode & ~btn_mode_q;
  assign next_edge = btn_next & ~btn_next_q;
  assign mode      = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                 <= RECORD;
      btn_mode_q            <= 1'b0;
      btn_next_q            <= 1'b0;
      timer                 <= '0;
      stash_sample_in_valid <= 1'b0;
      stash_next_sample     <= 1'b0;
      stash_sample_in       <= '0;
      fill                  <= '0;
    end else begin
      state                 <= state_nx;
      btn_mode_q            <= btn_mode;
      btn_next_q            <= btn_next;
      timer                 <= timer_nx;
      stash_sample_in_valid <= wr_nx;
      stash_next_sample     <= next_nx;
      stash_sample_in       <= data_nx;
      fill                  <= fill_nx;
    end
  end

  // All decisions use the pre-transition mode; a mode edge suppresses any next request.
  always_comb begin
    state_nx = state;
    timer_nx = '0;
    wr_nx    = 1'b0;
    next_nx  = 1'b0;
    data_nx  = stash_sample_in;
    fill_nx  = fill;
    case (state)
      RECORD: begin
        if (src_valid) begin
          wr_nx   = 1'b1;
          data_nx = src_data;
          if (fill != FILL_MAX) fill_nx = fill + 1'b1;
        end
        if (mode_edge) state_nx = BROWSE;
      end
      BROWSE: begin
        if (next_edge && !mode_edge && (fill != '0)) next_nx = 1'b1;
        if (mode_edge) state_nx = AUTO;
      end
      AUTO: begin
        if (mode_edge) begin
          state_nx = RECORD;
        end else if (timer == TIMER_MAX) begin
          timer_nx = '0;
          next_nx  = (fill != '0);
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      default: state_nx = RECORD;
    endcase
  end

`ifdef STASH_SEQ_DROP_CNT_EN
  logic refuse;
  assign refuse = src_valid & (state != RECORD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt <= '0;
    end else if (refuse && (drop_cnt != {CNT_W{1'b1}})) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_stash_sequencer.sv
// Bench for stash_sequencer: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_stash_sequencer;
  localparam int DEPTH = 5;
  localparam int DATA_W = 8;
  localparam int AUTO_PERIOD = 4;
  localparam int CNT_W = 8;
  localparam int FILL_W = $clog2(DEPTH + 1);
`ifdef STASH_SEQ_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  logic [DATA_W-1:0] src_data;
  logic src_valid, btn_mode, btn_next;
  logic [DATA_W-1:0] stash_sample_in;
  logic stash_sample_in_valid, stash_next_sample;
  logic [1:0] mode;
  logic [FILL_W-1:0] fill;
  logic [CNT_W-1:0] drop_cnt;

  int total = 0;
  int bad = 0;

  // reference model state
  int m_mode, m_fill, m_drop, m_cyc;
  bit m_pbm, m_pbn, e_wr, e_nx;
  logic [DATA_W-1:0] e_data;
  logic [DATA_W-1:0] exp_q[$];

  stash_sequencer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AUTO_PERIOD(AUTO_PERIOD), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .src_data(src_data), .src_valid(src_valid),
    .btn_mode(btn_mode), .btn_next(btn_next), .stash_sample_in(stash_sample_in),
    .stash_sample_in_valid(stash_sample_in_valid), .stash_next_sample(stash_next_sample),
    .mode(mode), .fill(fill), .drop_cnt(drop_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_drop();
    return DROP_EN ? m_drop : 0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_fill = 0; m_drop = 0; m_cyc = 0;
    m_pbm = 1'b0; m_pbn = 1'b0; e_wr = 1'b0; e_nx = 1'b0; e_data = '0;
    exp_q.delete();
  endtask

  // driver: apply one cycle of inputs, advance the model, return #1 after the clock edge
  task automatic step(input bit sv, input logic [DATA_W-1:0] d, input bit bm, input bit bn);
    bit me, ne;
    src_valid = sv; src_data = d; btn_mode = bm; btn_next = bn;
    me = bm && !m_pbm;
    ne = bn && !m_pbn;
    e_wr = (m_mode == 0) && sv;
    e_nx = 1'b0;
    if (e_wr) begin
      e_data = d;
      exp_q.push_back(d);
      if (m_fill < DEPTH) m_fill++;
    end
    if (m_mode != 0 && sv && m_drop < (1 << CNT_W) - 1) m_drop++;
    if (m_mode == 1 && ne && !me && m_fill != 0) e_nx = 1'b1;
    if (m_mode == 2 && !me) begin
      m_cyc++;
      if ((m_cyc % AUTO_PERIOD) == 0 && m_fill != 0) e_nx = 1'b1;
    end
    if (me) begin
      m_mode = (m_mode + 1) % 3;
      m_cyc = 0;
    end
    m_pbm = bm; m_pbn = bn;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    src_valid = 0; src_data = '0; btn_mode = 0; btn_next = 0;
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if ({stash_sample_in, stash_sample_in_valid, stash_next_sample} !== '0) begin
      bad++; $display("FAIL reset_strobes got=%h/%b/%b want=0", stash_sample_in, stash_sample_in_valid, stash_next_sample);
    end
    total++; if ({mode, fill, drop_cnt} !== '0) begin
      bad++; $display("FAIL reset_state mode=%0d fill=%0d drop=%0d want all 0", mode, fill, drop_cnt);
    end
    reset = 1'b1;
  endtask

  task automatic test_record();
    logic [DATA_W-1:0] d[3];
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, d[i], 1'b0, 1'b0);
      total++; if (stash_sample_in_valid !== 1'b1 || stash_sample_in !== d[i]) begin
        bad++; $display("FAIL rec_write%0d got v=%b d=%h want v=1 d=%h", i, stash_sample_in_valid, stash_sample_in, d[i]);
      end
      step(1'b0, 8'h00, 1'b0, 1'b0);
      total++; if (stash_sample_in_valid !== 1'b0) begin
        bad++; $display("FAIL rec_idle%0d got v=%b want 0", i, stash_sample_in_valid);
      end
    end
    total++; if (fill !== 3'd3 || mode !== 2'b00) begin
      bad++; $display("FAIL rec_fill got fill=%0d mode=%0d want 3/0", fill, mode);
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < 7; i++) begin
      d = DATA_W'($urandom_range(0, 255));
      step(1'b1, d, 1'b0, 1'b0);
      total++; if (stash_sample_in_valid !== 1'b1 || stash_sample_in !== d) begin
        bad++; $display("FAIL b2b_write%0d got v=%b d=%h want v=1 d=%h", i, stash_sample_in_valid, stash_sample_in, d);
      end
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    total++; if (fill !== 3'd5 || stash_sample_in_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_saturate got fill=%0d v=%b want 5/0", fill, stash_sample_in_valid);
    end
  endtask

  task automatic test_browse();
    int pulses = 0;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    total++; if (mode !== 2'b01) begin
      bad++; $display("FAIL browse_mode got=%0d want 1", mode);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, DATA_W'($urandom_range(0, 255)), 1'b0, 1'b0);
      total++; if (stash_sample_in_valid !== 1'b0 || stash_next_sample !== 1'b0) begin
        bad++; $display("FAIL browse_block%0d got v=%b n=%b want 0/0", i, stash_sample_in_valid, stash_next_sample);
      end
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b1);
      total++; if (stash_next_sample !== 1'b1) begin
        bad++; $display("FAIL browse_next%0d got=%b want 1", i, stash_next_sample);
      end
      pulses += int'(stash_next_sample);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      pulses += int'(stash_next_sample);
    end
    total++; if (pulses != 2) begin
      bad++; $display("FAIL browse_pulses got=%0d want 2", pulses);
    end
    total++; if (int'(drop_cnt) != (DROP_EN ? 3 : 0)) begin
      bad++; $display("FAIL browse_drop got=%0d want %0d", drop_cnt, DROP_EN ? 3 : 0);
    end
  endtask

  task automatic test_auto();
    int pulses = 0;
    bit bn, want;
    for (int c = 1; c <= 13; c++) begin
      bn = (c == 4) || (c == 7) || (c == 10);
      step(1'b0, 8'h00, 1'b1, bn);
      want = (c > 1) && (((c - 1) % 4) == 0);
      pulses += int'(stash_next_sample);
      total++; if (stash_next_sample !== want || mode !== 2'b10) begin
        bad++; $display("FAIL auto_cycle%0d got n=%b mode=%0d want n=%b mode=2", c, stash_next_sample, mode, want);
      end
    end
    total++; if (pulses != 3) begin
      bad++; $display("FAIL auto_pulses got=%0d want 3", pulses);
    end
  endtask

  task automatic test_empty();
    int pulses = 0;
    test_reset();
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    pulses += int'(stash_next_sample);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    pulses += int'(stash_next_sample);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    total++; if (mode !== 2'b10) begin
      bad++; $display("FAIL empty_mode got=%0d want 2", mode);
    end
    repeat (10) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      pulses += int'(stash_next_sample);
    end
    total++; if (pulses != 0 || fill !== '0) begin
      bad++; $display("FAIL empty_no_next got pulses=%0d fill=%0d want 0/0", pulses, fill);
    end
  endtask

  task automatic test_mode_with_write();
    test_reset();
    step(1'b1, 8'h5a, 1'b1, 1'b0);
    total++; if (stash_sample_in_valid !== 1'b1 || stash_sample_in !== 8'h5a || mode !== 2'b01 || fill !== 3'd1) begin
      bad++; $display("FAIL mode_write got v=%b d=%h mode=%0d fill=%0d want 1/5a/1/1",
                      stash_sample_in_valid, stash_sample_in, mode, fill);
    end
  endtask

  task automatic test_simultaneous();
    test_reset();
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    total++; if (mode !== 2'b10 || stash_next_sample !== 1'b0) begin
      bad++; $display("FAIL simul_edges got mode=%0d n=%b want 2/0", mode, stash_next_sample);
    end
    step(1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    total++; if ({stash_sample_in, stash_sample_in_valid, stash_next_sample, mode, fill, drop_cnt} !== '0) begin
      bad++; $display("FAIL async_reset got d=%h v=%b n=%b mode=%0d fill=%0d drop=%0d want all 0",
                      stash_sample_in, stash_sample_in_valid, stash_next_sample, mode, fill, drop_cnt);
    end
    src_valid = 0; btn_mode = 0; btn_next = 0;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    total++; if (stash_next_sample !== 1'b0 || mode !== 2'b00) begin
      bad++; $display("FAIL post_reset got n=%b mode=%0d want 0/0", stash_next_sample, mode);
    end
  endtask

  task automatic test_drop_saturate();
    test_reset();
    step(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (260) step(1'b1, 8'h00, 1'b0, 1'b0);
    total++; if (int'(drop_cnt) != (DROP_EN ? 255 : 0)) begin
      bad++; $display("FAIL drop_saturate got=%0d want %0d", drop_cnt, DROP_EN ? 255 : 0);
    end
  endtask

  task automatic test_random();
    bit sv, bm, bn;
    logic [DATA_W-1:0] d, got;
    test_reset();
    for (int i = 0; i < 400; i++) begin
      sv = ($urandom_range(0, 1) == 1);
      bm = ($urandom_range(0, 9) == 0);
      bn = ($urandom_range(0, 2) == 0);
      d = DATA_W'($urandom);
      step(sv, d, bm, bn);
      total++; if (stash_sample_in_valid !== e_wr || stash_next_sample !== e_nx) begin
        bad++; $display("FAIL rnd_strobes@%0d got v=%b n=%b want v=%b n=%b", i, stash_sample_in_valid, stash_next_sample, e_wr, e_nx);
      end
      total++; if (int'(mode) != m_mode || int'(fill) != m_fill || int'(drop_cnt) != exp_drop()) begin
        bad++; $display("FAIL rnd_state@%0d got mode=%0d fill=%0d drop=%0d want %0d/%0d/%0d",
                        i, mode, fill, drop_cnt, m_mode, m_fill, exp_drop());
      end
      total++; if (stash_sample_in !== e_data) begin
        bad++; $display("FAIL rnd_data@%0d got=%h want=%h", i, stash_sample_in, e_data);
      end
      if (stash_sample_in_valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rnd_sb@%0d unexpected write d=%h", i, stash_sample_in);
        end else begin
          got = exp_q.pop_front();
          if (stash_sample_in !== got) begin
            bad++; $display("FAIL rnd_sb@%0d got=%h want=%h", i, stash_sample_in, got);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_record();
    test_back_to_back();
    test_browse();
    test_auto();
    test_empty();
    test_mode_with_write();
    test_simultaneous();
    test_drop_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
